// File: rtl/fetch_stage_pkg.sv
// Core-wide constants shared by the pipeline stages: reset vector, bubble encoding
// and the instruction field positions used by fetch and decode.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // All-zero word is sll $0,$0,0: a harmless rType bubble.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned JIDX_MSB   = 25;
  localparam int unsigned JIDX_LSB   = 0;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [XLEN-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control and data bundle between the fetch stage, the hazard unit, decode and
// instruction memory.
interface fetch_stage_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  StallF;
  logic                  StallD;
  logic                  FlushD;
  logic                  PCSrcD;
  logic [ADDR_WIDTH-1:0] PCBranchD;
  logic                  JumpD;
  logic [DATA_WIDTH-1:0] InstrF;
  logic [ADDR_WIDTH-1:0] PCF;
  logic [DATA_WIDTH-1:0] InstrD;
  logic [ADDR_WIDTH-1:0] PCPlus4D;
  logic                  ValidD;

  // Surrounding core: hazard unit, decode and instruction memory.
  modport master (
    output StallF, StallD, FlushD, PCSrcD, PCBranchD, JumpD, InstrF,
    input  PCF, InstrD, PCPlus4D, ValidD
  );

  // The fetch stage itself.
  modport slave (
    input  StallF, StallD, FlushD, PCSrcD, PCBranchD, JumpD, InstrF,
    output PCF, InstrD, PCPlus4D, ValidD
  );

endinterface

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register with reset > stall > flush > load priority; the same
// pattern is reused for the later pipeline registers.
module if_id_register
  import fetch_stage_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic [DATA_WIDTH-1:0] InstrF,
  input  logic [ADDR_WIDTH-1:0] PCPlus4F,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [ADDR_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD
);

  logic [DATA_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0] pc_plus4_q;
  logic                  valid_q;

  // A stalled instruction must survive, so stall masks a concurrent flush.
  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_q    <= DATA_WIDTH'(NOP_INSTR);
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (StallD) begin
      instr_q    <= instr_q;
      pc_plus4_q <= pc_plus4_q;
      valid_q    <= valid_q;
    end else if (FlushD) begin
      instr_q    <= DATA_WIDTH'(NOP_INSTR);
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= InstrF;
      pc_plus4_q <= PCPlus4F;
      valid_q    <= 1'b1;
    end
  end

  assign InstrD   = instr_q;
  assign PCPlus4D = pc_plus4_q;
  assign ValidD   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID register
// feeding decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input logic          CLK,
  input logic          RST,
  fetch_stage_if.slave bus
);

  logic [ADDR_WIDTH-1:0] pcf_q;
  logic [ADDR_WIDTH-1:0] pc_plus4_f;
  logic [ADDR_WIDTH-1:0] jump_target_d;
  logic [ADDR_WIDTH-1:0] pc_next;

  assign pc_plus4_f = pcf_q + ADDR_WIDTH'(4);

  always_comb begin
    jump_target_d       = bus.PCPlus4D;
    jump_target_d[27:0] = {bus.InstrD[JIDX_MSB:JIDX_LSB], 2'b00};
  end

  // A bubble in decode carries no jump index, so JumpD only counts with ValidD.
  always_comb begin
    pc_next = pc_plus4_f;
    if (bus.JumpD && bus.ValidD) begin
      pc_next = jump_target_d;
    end else if (bus.PCSrcD) begin
      pc_next = bus.PCBranchD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pcf_q <= RESET_PC;
    end else if (!bus.StallF) begin
      pcf_q <= pc_next;
    end
  end

  assign bus.PCF = pcf_q;

  if_id_register #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_if_id (
    .CLK      (CLK),
    .RST      (RST),
    .StallD   (bus.StallD),
    .FlushD   (bus.FlushD),
    .InstrF   (bus.InstrF),
    .PCPlus4F (pc_plus4_f),
    .InstrD   (bus.InstrD),
    .PCPlus4D (bus.PCPlus4D),
    .ValidD   (bus.ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall, branch, jump,
// stall-over-flush, PC wrap and reset priority.
module tb_fetch_stage;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  fetch_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  fetch_stage #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory: one planted jump word, otherwise an address-tagged pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h1000_0004) return 32'h0800_0010;
    return 32'hC000_0000 | addr;
  endfunction

  assign bus.InstrF = mem_word(bus.PCF);

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_ctrl();
    bus.StallF    = 1'b0;
    bus.StallD    = 1'b0;
    bus.FlushD    = 1'b0;
    bus.PCSrcD    = 1'b0;
    bus.PCBranchD = 32'h0;
    bus.JumpD     = 1'b0;
  endtask

  task automatic test_reset();
    clear_ctrl();
    RST = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.PCF !== 32'h0) begin
      errors++; $display("FAIL reset_pcf got %h exp %h", bus.PCF, 32'h0);
    end
    checks++;
    if (bus.InstrD !== 32'h0) begin
      errors++; $display("FAIL reset_instrd got %h exp %h", bus.InstrD, 32'h0);
    end
    checks++;
    if (bus.PCPlus4D !== 32'h0) begin
      errors++; $display("FAIL reset_pcplus4d got %h exp %h", bus.PCPlus4D, 32'h0);
    end
    checks++;
    if (bus.ValidD !== 1'b0) begin
      errors++; $display("FAIL reset_validd got %b exp 0", bus.ValidD);
    end
    RST = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (bus.PCF !== 32'(4 * i)) begin
        errors++; $display("FAIL seq_pcf[%0d] got %h exp %h", i, bus.PCF, 32'(4 * i));
      end
      checks++;
      if (bus.InstrD !== mem_word(32'(4 * (i - 1)))) begin
        errors++;
        $display("FAIL seq_instrd[%0d] got %h exp %h", i, bus.InstrD, mem_word(32'(4 * (i - 1))));
      end
      checks++;
      if (bus.PCPlus4D !== 32'(4 * i)) begin
        errors++; $display("FAIL seq_pcplus4d[%0d] got %h exp %h", i, bus.PCPlus4D, 32'(4 * i));
      end
      checks++;
      if (bus.ValidD !== 1'b1) begin
        errors++; $display("FAIL seq_validd[%0d] got %b exp 1", i, bus.ValidD);
      end
    end
  endtask

  task automatic test_stall();
    bus.StallF = 1'b1;
    bus.StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.PCF !== 32'h10) begin
        errors++; $display("FAIL stall_pcf[%0d] got %h exp %h", i, bus.PCF, 32'h10);
      end
      checks++;
      if (bus.InstrD !== 32'hC000_000C || bus.PCPlus4D !== 32'h10) begin
        errors++;
        $display("FAIL stall_ifid[%0d] got %h/%h exp %h/%h", i, bus.InstrD, bus.PCPlus4D,
                 32'hC000_000C, 32'h10);
      end
    end
    clear_ctrl();
    tick();
    checks++;
    if (bus.PCF !== 32'h14 || bus.InstrD !== 32'hC000_0010 || bus.PCPlus4D !== 32'h14) begin
      errors++;
      $display("FAIL stall_release got %h/%h/%h exp %h/%h/%h", bus.PCF, bus.InstrD,
               bus.PCPlus4D, 32'h14, 32'hC000_0010, 32'h14);
    end
    tick();
  endtask

  task automatic test_branch();
    checks++;
    if (bus.PCF !== 32'h18) begin
      errors++; $display("FAIL branch_start_pcf got %h exp %h", bus.PCF, 32'h18);
    end
    bus.PCSrcD    = 1'b1;
    bus.PCBranchD = 32'h40;
    bus.FlushD    = 1'b1;
    tick();
    clear_ctrl();
    checks++;
    if (bus.PCF !== 32'h40 || bus.InstrD !== 32'h0 || bus.ValidD !== 1'b0) begin
      errors++;
      $display("FAIL branch_redirect got %h/%h/%b exp %h/%h/0", bus.PCF, bus.InstrD,
               bus.ValidD, 32'h40, 32'h0);
    end
    tick();
    checks++;
    if (bus.InstrD !== 32'hC000_0040 || bus.PCPlus4D !== 32'h44 || bus.ValidD !== 1'b1) begin
      errors++;
      $display("FAIL branch_target_instr got %h/%h/%b exp %h/%h/1", bus.InstrD,
               bus.PCPlus4D, bus.ValidD, 32'hC000_0040, 32'h44);
    end
  endtask

  task automatic test_jump();
    bus.PCSrcD    = 1'b1;
    bus.PCBranchD = 32'h1000_0004;
    bus.FlushD    = 1'b1;
    tick();
    clear_ctrl();
    tick();
    checks++;
    if (bus.InstrD !== 32'h0800_0010 || bus.PCPlus4D !== 32'h1000_0008) begin
      errors++;
      $display("FAIL jump_setup got %h/%h exp %h/%h", bus.InstrD, bus.PCPlus4D,
               32'h0800_0010, 32'h1000_0008);
    end
    bus.JumpD  = 1'b1;
    bus.FlushD = 1'b1;
    tick();
    bus.FlushD = 1'b0;
    checks++;
    if (bus.PCF !== 32'h1000_0040 || bus.ValidD !== 1'b0) begin
      errors++;
      $display("FAIL jump_redirect got %h/%b exp %h/0", bus.PCF, bus.ValidD, 32'h1000_0040);
    end
    // JumpD still high but decode holds a bubble: must fall through to PC+4.
    tick();
    bus.JumpD = 1'b0;
    checks++;
    if (bus.PCF !== 32'h1000_0044) begin
      errors++; $display("FAIL jump_bubble_ignored got %h exp %h", bus.PCF, 32'h1000_0044);
    end
    // InstrD = 0xD0000040, index 0x40 -> 0x1000_0100; jump must beat the branch.
    bus.JumpD     = 1'b1;
    bus.PCSrcD    = 1'b1;
    bus.PCBranchD = 32'h80;
    bus.FlushD    = 1'b1;
    tick();
    clear_ctrl();
    checks++;
    if (bus.PCF !== 32'h1000_0100) begin
      errors++; $display("FAIL jump_over_branch got %h exp %h", bus.PCF, 32'h1000_0100);
    end
  endtask

  task automatic test_stall_flush();
    tick();
    bus.StallD = 1'b1;
    bus.FlushD = 1'b1;
    tick();
    clear_ctrl();
    checks++;
    if (bus.InstrD !== 32'hD000_0100 || bus.ValidD !== 1'b1 || bus.PCPlus4D !== 32'h1000_0104)
    begin
      errors++;
      $display("FAIL stall_over_flush got %h/%b/%h exp %h/1/%h", bus.InstrD, bus.ValidD,
               bus.PCPlus4D, 32'hD000_0100, 32'h1000_0104);
    end
    checks++;
    if (bus.PCF !== 32'h1000_0108) begin
      errors++; $display("FAIL stall_flush_pcf got %h exp %h", bus.PCF, 32'h1000_0108);
    end
  endtask

  task automatic test_wrap();
    bus.PCSrcD    = 1'b1;
    bus.PCBranchD = 32'hFFFF_FFFC;
    tick();
    clear_ctrl();
    checks++;
    if (bus.PCF !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_setup got %h exp %h", bus.PCF, 32'hFFFF_FFFC);
    end
    tick();
    checks++;
    if (bus.PCF !== 32'h0 || bus.PCPlus4D !== 32'h0 || bus.InstrD !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_pc got %h/%h/%h exp %h/%h/%h", bus.PCF, bus.PCPlus4D, bus.InstrD,
               32'h0, 32'h0, 32'hFFFF_FFFC);
    end
  endtask

  task automatic test_reset_priority();
    tick();
    RST           = 1'b1;
    bus.StallF    = 1'b1;
    bus.StallD    = 1'b1;
    bus.PCSrcD    = 1'b1;
    bus.PCBranchD = 32'h80;
    tick();
    checks++;
    if (bus.PCF !== 32'h0 || bus.ValidD !== 1'b0 || bus.InstrD !== 32'h0) begin
      errors++;
      $display("FAIL reset_priority got %h/%b/%h exp %h/0/%h", bus.PCF, bus.ValidD,
               bus.InstrD, 32'h0, 32'h0);
    end
    RST = 1'b0;
    clear_ctrl();
    tick();
    checks++;
    if (bus.PCF !== 32'h4 || bus.InstrD !== 32'hC000_0000 || bus.ValidD !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_fetch got %h/%h/%b exp %h/%h/1", bus.PCF, bus.InstrD,
               bus.ValidD, 32'h4, 32'hC000_0000);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST    = 1'b1;
    clear_ctrl();
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump();
    test_stall_flush();
    test_wrap();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
